mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Data-bus master for the MEM stage of the yadan pipeline, and the source of the pipeline controller's `stallreq_from_mem` input. It accepts one load or store at a time from the MEM stage and runs it as a req/ack transaction on the data bus. While the transaction is outstanding it holds a stall request. It returns read data, completion and error status, and handles pipeline flush and bus timeout.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of `BUSY` cycles without ack before the access is aborted with an error. Legal range 2..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`RstEnable` = 1'b0).
- `mem_req_i`  in  1  MEM stage requests a data access.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  32  store data, already lane-aligned.
- `mem_sel_i`  in  4  byte strobes.
- `flush_i`  in  1  pipeline flush of the MEM stage.
- `mem_rdata_o`  out  32  captured read data.
- `mem_done_o`  out  1  one-cycle access-complete pulse.
- `mem_err_o`  out  1  qualifies `mem_done_o`: bus error, timeout or misalignment.
- `stallreq_o`  out  1  to the controller's `stallreq_from_mem`; `Stop` = 1.
- `bus_req_o`  out  1  bus request, registered.
- `bus_we_o`  out  1  bus write enable.
- `bus_addr_o`  out  32  bus address.
- `bus_wdata_o`  out  32  bus write data.
- `bus_sel_o`  out  4  bus byte strobes.
- `bus_ack_i`  in  1  slave completes the transfer this cycle.
- `bus_err_i`  in  1  slave error; valid only together with `bus_ack_i`.
- `bus_rdata_i`  in  32  read data; valid only together with `bus_ack_i`.

## Operation
- State machine with four states: `IDLE`, `BUSY`, `DONE`, `DRAIN`.
- **IDLE, `mem_req_i`=1, `flush_i`=0:**
  - Register we/addr/wdata/sel onto the `bus_*` outputs and go to `BUSY`.
  - `stallreq_o` is asserted combinationally in the same cycle.
- **IDLE, misaligned request:** `sel`=1111 with `addr[1:0]`≠0, or `sel` in {0011, 1100} with `addr[0]`≠0.
  - No bus request is issued; go to `DONE` with the error flag set.
  - `stallreq_o` is asserted for this one cycle.
- **BUSY:**
  - `bus_req_o`=1 and `stallreq_o`=1.
  - All `bus_*` outputs are held stable.
  - The 8-bit timeout counter increments each cycle.
- **BUSY exits:**
  - `bus_ack_i`=1: capture `bus_rdata_i` (loads only; stores leave `mem_rdata_o` unchanged), set the error flag to `bus_err_i`, go to `DONE`.
  - Counter reaches `TIMEOUT_CYCLES`-1 with no ack: drop `bus_req_o`, set the error flag, go to `DONE`.
- **DONE:**
  - `mem_done_o`=1, `mem_err_o`=error flag, `stallreq_o`=0, so the pipeline advances at the end of this cycle.
  - `mem_req_i` is ignored here (it still belongs to the completed instruction). Always go to `IDLE`.
- **Flush in BUSY:** a bus transfer is never retracted.
  - Go to `DRAIN`; `bus_req_o` stays high until ack or timeout.
  - The result is discarded and `mem_done_o` is not pulsed.
  - Then go to `IDLE`.
- **DRAIN:** `stallreq_o` = `mem_req_i`, so a new access waits until the bus is free.
- **Flush in IDLE or DONE:** the incoming request is not started; no outputs pulse.
- **Reset (asynchronous, any state):**
  - State = `IDLE`, counter = 0.
  - All outputs 0; `mem_rdata_o` = 0.
  - `bus_req_o` drops immediately, without waiting for a clock edge.

## Timing
- Request seen in IDLE at cycle 0 → `bus_req_o` high from cycle 1.
- Ack at cycle k≥1 → `mem_done_o` and `stallreq_o`=0 at cycle k+1; `bus_req_o` low at k+1.
- Minimum stall: 2 cycles (ack at cycle 1). Total MEM occupancy is k+2 cycles.
- Misaligned access: stall 1 cycle, `mem_done_o` at cycle 1.
- Timeout: `bus_req_o` is high for exactly `TIMEOUT_CYCLES` cycles, then `DONE`.
- Back-to-back accesses: the next request is accepted in `IDLE` at k+2, never in `DONE`.
- Bus rule: a transfer completes on any cycle where `bus_req_o` and `bus_ack_i` are both sampled high. `bus_ack_i` while `bus_req_o`=0 is ignored.
- Ack and flush in the same BUSY cycle: the ack wins for the bus (transfer complete), but the result is discarded; go to `IDLE`, no `mem_done_o`.

## Test plan
- **Load, ack at 3rd BUSY cycle.**
  - Stimulus: load from 0x0000_1000, sel=1111; `bus_rdata_i`=0xDEAD_BEEF.
  - Required: `stallreq_o` high for cycles 0–3; `mem_done_o` at cycle 4 with `mem_rdata_o`=0xDEAD_BEEF and `mem_err_o`=0.
- **Store.**
  - Stimulus: store to 0x0000_2002, sel=1100, wdata=0x1234_0000; ack at cycle 1.
  - Required: `bus_we_o`=1 and `bus_*` stable while `bus_req_o` high; done at cycle 2; `mem_rdata_o` unchanged.
- **Misaligned load.** Load at 0x0000_0003, sel=1111 → `bus_req_o` never asserted; `mem_done_o`=1 and `mem_err_o`=1 at cycle 1.
- **Timeout.** `TIMEOUT_CYCLES`=4, no ack → `bus_req_o` high for cycles 1–4; done with err at cycle 5.
- **Flush mid-access.** Flush at cycle 2, ack at cycle 5, new request at cycle 3 → `stallreq_o` high for cycles 3–5; no done pulse for the first access; second access `bus_req_o` from cycle 7.
- **Reset mid-access.** `rst`=0 during BUSY → `bus_req_o`, `stallreq_o` and `mem_rdata_o` all 0 before the next clock edge; the first request after reset behaves as in the first scenario.

Source files
------------

// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
//
// Data-bus master for the MEM stage. Accepts one load or store at a time,
// runs it as a req/ack transaction on the data bus and holds a stall request
// toward the pipeline controller while the transfer is outstanding. Returns
// read data plus a one-cycle done pulse qualified by an error flag, and
// handles pipeline flush (transfer is drained, result dropped) and bus
// timeout (request withdrawn, access completes with error).
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   mem_req_i ...     MEM-stage access request (we/addr/wdata/sel)
//   flush_i           pipeline flush of the MEM stage
//   mem_rdata_o       captured load data
//   mem_done_o        one-cycle completion pulse
//   mem_err_o         qualifies mem_done_o: bus error, timeout or misalignment
//   stallreq_o        stall request to the pipeline controller
//   bus_*_o           registered bus request, held stable while outstanding
//   bus_ack_i         slave completes the transfer this cycle
//   bus_err_i         slave error, valid with bus_ack_i
//   bus_rdata_i       read data, valid with bus_ack_i
// -----------------------------------------------------------------------------
module mem_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16  // legal range 2..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    input  logic        flush_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_err_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        DRAIN
    } state_e;

    // Counter value on the last BUSY/DRAIN cycle before the access is aborted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;

    logic        stall;
    logic        done;
    logic        misaligned;
    logic        timeout;

    // Word access must be word aligned; halfword access must be halfword aligned.
    assign misaligned = ((mem_sel_i == 4'b1111) && (mem_addr_i[1:0] != 2'b00)) ||
                        (((mem_sel_i == 4'b0011) || (mem_sel_i == 4'b1100)) &&
                         mem_addr_i[0]);

    assign timeout = (cnt_q == CNT_LAST);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        stall       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_req_i && !flush_i) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        // Reject without touching the bus.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_we_i;
                        bus_addr_d  = mem_addr_i;
                        bus_wdata_d = mem_wdata_i;
                        bus_sel_d   = mem_sel_i;
                        cnt_d       = 8'd0;
                        state_d     = BUSY;
                    end
                end
            end

            BUSY: begin
                stall = 1'b1;
                if (bus_ack_i) begin
                    // The transfer is complete on the bus even when flushed;
                    // a flush only discards the result.
                    bus_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        err_d   = bus_err_i;
                        if (!bus_we_q) begin
                            rdata_d = bus_rdata_i;
                        end
                        state_d = DONE;
                    end
                end else if (timeout) begin
                    bus_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (flush_i) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // A new access must wait until the abandoned transfer ends.
                stall = mem_req_i;
                if (bus_ack_i || timeout) begin
                    bus_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                // mem_req_i still belongs to the completing instruction here.
                done    = !flush_i;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_sel_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
        end
    end

    // The stall path is combinational from mem_req_i, so it is gated by reset
    // to keep every output low while reset is held.
    assign stallreq_o  = stall & rst;
    assign mem_done_o  = done;
    assign mem_err_o   = done & err_q;
    assign mem_rdata_o = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_sel_o   = bus_sel_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_master
//
// Directed bench for mem_bus_master. Two instances share all inputs: dut uses
// the default timeout of 16, dut_t4 uses a timeout of 4 for the timeout
// scenario. Inputs are driven 1 time unit after the rising edge and outputs
// are sampled 1 time unit later. Per-cycle control outputs are compared as
// {stallreq, bus_req, done, err} against hand-written tables.
// -----------------------------------------------------------------------------
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        flush;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    logic [31:0] rdata,  rdata_t4;
    logic        done,   done_t4;
    logic        err,    err_t4;
    logic        stall,  stall_t4;
    logic        breq,   breq_t4;
    logic        bwe,    bwe_t4;
    logic [31:0] baddr,  baddr_t4;
    logic [31:0] bwdata, bwdata_t4;
    logic [3:0]  bsel,   bsel_t4;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_master dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .flush_i(flush),
        .mem_rdata_o(rdata), .mem_done_o(done), .mem_err_o(err),
        .stallreq_o(stall), .bus_req_o(breq), .bus_we_o(bwe),
        .bus_addr_o(baddr), .bus_wdata_o(bwdata), .bus_sel_o(bsel),
        .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata)
    );

    mem_bus_master #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .flush_i(flush),
        .mem_rdata_o(rdata_t4), .mem_done_o(done_t4), .mem_err_o(err_t4),
        .stallreq_o(stall_t4), .bus_req_o(breq_t4), .bus_we_o(bwe_t4),
        .bus_addr_o(baddr_t4), .bus_wdata_o(bwdata_t4), .bus_sel_o(bsel_t4),
        .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        #3;
        obs = {stall, breq, done, err};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", obs);
        end
        n_checks++;
        if ({bwe, baddr, bwdata, bsel, rdata} !== 101'd0) begin
            n_fail++;
            $display("FAIL reset_data: got we=%b addr=%h wdata=%h sel=%b rdata=%h expected all zero",
                     bwe, baddr, bwdata, bsel, rdata);
        end
        tick();
        #2 rst = 1'b1;
        tick();
    endtask

    // Load from 0x1000, ack on the third BUSY cycle (cycle 3).
    task automatic test_load();
        logic [3:0] exp [6] = '{4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b0000};
        logic [3:0] obs;
        mem_we = 1'b0; mem_addr = 32'h0000_1000; mem_sel = 4'b1111; mem_wdata = 32'h0;
        for (int c = 0; c < 6; c++) begin
            mem_req   = (c <= 4);
            bus_ack   = (c == 3);
            bus_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            #1;
            obs = {stall, breq, done, err};
            n_checks++;
            if (obs !== exp[c]) begin
                n_fail++;
                $display("FAIL load_ctrl c%0d: got %b expected %b", c, obs, exp[c]);
            end
            if (c == 1) begin
                n_checks++;
                if ({bwe, baddr, bsel} !== {1'b0, 32'h0000_1000, 4'b1111}) begin
                    n_fail++;
                    $display("FAIL load_bus: got we=%b addr=%h sel=%b expected 0 00001000 1111",
                             bwe, baddr, bsel);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (rdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL load_rdata: got %h expected deadbeef", rdata);
                end
            end
            tick();
        end
        bus_ack = 1'b0;
    endtask

    // Store to 0x2002 with sel 1100, ack at cycle 1; mem inputs change while
    // the transfer is outstanding to show the bus side is registered.
    task automatic test_store();
        logic [3:0] exp [4] = '{4'b1000, 4'b1100, 4'b0010, 4'b0000};
        logic [3:0] obs;
        for (int c = 0; c < 4; c++) begin
            mem_req   = (c <= 2);
            mem_we    = (c == 0);
            mem_addr  = (c == 0) ? 32'h0000_2002 : 32'hFFFF_FFF0;
            mem_wdata = (c == 0) ? 32'h1234_0000 : 32'h0;
            mem_sel   = (c == 0) ? 4'b1100 : 4'b0001;
            bus_ack   = (c == 1);
            bus_rdata = 32'hFFFF_FFFF;
            #1;
            obs = {stall, breq, done, err};
            n_checks++;
            if (obs !== exp[c]) begin
                n_fail++;
                $display("FAIL store_ctrl c%0d: got %b expected %b", c, obs, exp[c]);
            end
            if (c == 1) begin
                n_checks++;
                if ({bwe, baddr, bwdata, bsel} !== {1'b1, 32'h0000_2002, 32'h1234_0000, 4'b1100}) begin
                    n_fail++;
                    $display("FAIL store_bus: got we=%b addr=%h wdata=%h sel=%b expected 1 00002002 12340000 1100",
                             bwe, baddr, bwdata, bsel);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (rdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL store_rdata: got %h expected deadbeef", rdata);
                end
            end
            tick();
        end
        bus_ack = 1'b0;
        mem_we  = 1'b0;
    endtask

    // Word load at 0x3: rejected without a bus request.
    task automatic test_misaligned();
        logic [3:0] exp [3] = '{4'b1000, 4'b0011, 4'b0000};
        logic [3:0] obs;
        mem_we = 1'b0; mem_addr = 32'h0000_0003; mem_sel = 4'b1111;
        bus_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_req = (c <= 1);
            #1;
            obs = {stall, breq, done, err};
            n_checks++;
            if (obs !== exp[c]) begin
                n_fail++;
                $display("FAIL misaligned_ctrl c%0d: got %b expected %b", c, obs, exp[c]);
            end
            tick();
        end
    endtask

    // Flush at cycle 2, ack for the drained transfer at cycle 5, new request
    // from cycle 3; second access gets a slave error at cycle 8.
    task automatic test_flush();
        logic [3:0] exp [11] = '{4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                                 4'b1000, 4'b1100, 4'b1100, 4'b0011, 4'b0000};
        logic [3:0] obs;
        mem_we = 1'b0; mem_sel = 4'b1111;
        for (int c = 0; c < 11; c++) begin
            mem_req   = (c <= 1) || (c >= 3 && c <= 9);
            mem_addr  = (c <= 2) ? 32'h0000_3000 : 32'h0000_4000;
            flush     = (c == 2);
            bus_ack   = (c == 5) || (c == 8);
            bus_err   = (c == 8);
            bus_rdata = (c == 5) ? 32'h1111_1111 : 32'h5555_AAAA;
            #1;
            obs = {stall, breq, done, err};
            n_checks++;
            if (obs !== exp[c]) begin
                n_fail++;
                $display("FAIL flush_ctrl c%0d: got %b expected %b", c, obs, exp[c]);
            end
            if (c == 6) begin
                n_checks++;
                if (rdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL flush_discard: got %h expected deadbeef", rdata);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (baddr !== 32'h0000_4000) begin
                    n_fail++;
                    $display("FAIL flush_second_addr: got %h expected 00004000", baddr);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (rdata !== 32'h5555_AAAA) begin
                    n_fail++;
                    $display("FAIL flush_second_rdata: got %h expected 5555aaaa", rdata);
                end
            end
            tick();
        end
        flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    endtask

    // Timeout of 4 on dut_t4: bus_req high cycles 1..4, done with error at 5.
    task automatic test_timeout();
        logic [3:0] exp [7] = '{4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0011, 4'b0000};
        logic [3:0] obs;
        mem_we = 1'b0; mem_addr = 32'h0000_5000; mem_sel = 4'b1111;
        bus_ack = 1'b0;
        for (int c = 0; c < 7; c++) begin
            mem_req = (c <= 5);
            #1;
            obs = {stall_t4, breq_t4, done_t4, err_t4};
            n_checks++;
            if (obs !== exp[c]) begin
                n_fail++;
                $display("FAIL timeout_ctrl c%0d: got %b expected %b", c, obs, exp[c]);
            end
            tick();
        end
    endtask

    // dut is still waiting on the timeout-test request (16-cycle timeout),
    // so it is mid-access here. Reset must clear outputs before the next edge.
    task automatic test_reset_mid();
        mem_req = 1'b1;
        #1;
        n_checks++;
        if (breq !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: bus_req got %b expected 1", breq);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({breq, stall, done, err, rdata} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got req=%b stall=%b done=%b err=%b rdata=%h expected all zero",
                     breq, stall, done, err, rdata);
        end
        mem_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        tick();
        test_load();
    endtask

    initial begin
        rst = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_sel = 4'h0; flush = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;

        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_flush();
        test_timeout();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
